gpio_cfg_serializer: RTL and testbench
======================================

// Module: gpio_cfg_serializer
// PURPOSE
// - Upstream feeder for the user-area GPIO config chains. Sits in the mgmt SoC and drives
//   mprj_io_loader_{resetn,clock,data_1,data_2}.
// - On a start pulse it reads one config word per pad from the GPIO config register file.
// - It shifts the words MSB-first into two parallel serial chains, then issues an apply strobe.
// PARAMETERS
// PADS   19  pads per chain (chain 1 = data_1, chain 2 = data_2); word index k = 0..PADS-1
// BITS   13  config bits per pad
// DIV_W  8   width of clk_div
// PORTS
// clk                    in   1      system clock
// reset                  in   1      asynchronous, active-high reset
// xfer_start             in   1      1-cycle pulse: begin transfer (ignored while busy)
// clk_div                in   DIV_W  loader clock half-period in clk cycles; 0 treated as 1
// cfg_addr               out  6      pad index k being fetched from register file
// cfg_data_1             in   BITS   chain-1 word for pad cfg_addr (combinational read)
// cfg_data_2             in   BITS   chain-2 word for pad cfg_addr (combinational read)
// busy                   out  1      high from cycle after xfer_start until done
// done                   out  1      1-cycle pulse at end of transfer
// mprj_io_loader_resetn  out  1      chain reset: 0 while reset, 1 otherwise
// mprj_io_loader_clock   out  1      serial shift clock (chains sample on rising edge)
// mprj_io_loader_data_1  out  1      chain-1 serial data
// mprj_io_loader_data_2  out  1      chain-2 serial data
// mprj_io_loader_strobe  out  1      apply strobe: chains copy shift regs to config
// BEHAVIOUR
// - Reset values: busy=0, done=0, cfg_addr=PADS-1, loader_clock=0, data_1=data_2=0,
//   strobe=0, resetn=0.
// - After reset deasserts, resetn=1 (registered, one clk later).
// - Reset mid-transfer aborts at once: all outputs return to reset values; no strobe, no done.
// - Latch D = max(clk_div,1) on the accepted xfer_start. clk_div changes mid-transfer are ignored.
// - FSM: IDLE -> FETCH -> SHIFT -> (FETCH | STROBE) -> DONE -> IDLE.
// - IDLE: on xfer_start go to FETCH; cfg_addr=PADS-1; busy=1 from the next cycle.
// - FETCH (1 cycle):
//   - capture cfg_data_1/cfg_data_2 into 13-bit shift regs sh1/sh2;
//   - bit counter = BITS-1; loader_clock=0.
// - SHIFT, per bit:
//   - low phase (D cycles): clock=0, data_1=sh1[MSB], data_2=sh2[MSB]; data changes only at
//     start of low phase;
//   - high phase (D cycles): clock=1, data held stable.
//   - At end of high phase, shift sh1/sh2 left by 1.
// - After the last bit of a word:
//   - cfg_addr != 0: decrement cfg_addr, go to FETCH.
//   - cfg_addr == 0: go to STROBE.
// - Pad PADS-1 is shifted first, so after PADS words it sits at the far end of the chain.
// - STROBE: clock=0, strobe=1 for 2*D cycles; data held at last value.
// - DONE (1 cycle): done=1, busy=0 in the same cycle, cfg_addr=PADS-1, data_1=data_2=0.
// - Latency, xfer_start to done = 1 + PADS*(1 + BITS*2*D) + 2*D cycles.
//   D=1, defaults: 1+19*27+2 = 516.
// - Rising loader_clock edges per transfer = PADS*BITS exactly (247 default).
// - Setup and hold of data around each rising edge >= D clk cycles.
// - xfer_start coincident with the DONE cycle is ignored.
// - xfer_start is accepted from IDLE only; a pulse arriving while busy is dropped, not queued.
// - Counters: div counter DIV_W bits, bit counter ceil(log2(BITS)), word counter = cfg_addr.
//   None may wrap except as defined above.
// TESTING
// - Word patterns:
//   - stimulus: D=1, cfg_data_1 = 13'h1000>>k pattern, cfg_data_2 = ~cfg_data_1;
//     model chains as 247-bit shift regs on clock rise;
//   - required: after strobe, chain-1 slot k == reg[k] for all 19 pads, chain 2 likewise;
//     done at cycle 516.
// - Divider:
//   - clk_div=3: high/low phases exactly 3 clk each, done at 1+19*79+6 = 1508 cycles;
//   - clk_div=0: identical timing to clk_div=1.
// - Start while busy: pulse xfer_start at cycles 10 and 300 of a transfer -> single transfer,
//   one done pulse, 247 rising edges.
// - Async reset mid-transfer: assert reset at cycle 200 -> outputs at reset values before
//   next clk edge, strobe never asserted; new xfer_start after release completes normally.
// - Back-to-back transfers: xfer_start in DONE cycle ignored; xfer_start the cycle after DONE
//   -> second full transfer with identical waveform.
// - clk_div change mid-transfer (1 -> 5 at cycle 50) -> timing stays D=1 until done.

Source files
------------

// File: rtl/gpio_cfg_serializer.sv
// Serializes per-pad GPIO config words MSB-first into two parallel loader chains,
// highest pad first, then pulses the apply strobe and reports done.
//
// Handshake: xfer_start is a single-cycle request sampled only in IDLE; busy is
// high from the following cycle through STROBE, and done pulses for exactly one
// cycle (with busy already low) when the chains have been strobed.
module gpio_cfg_serializer #(
   parameter int PADS  = 19,
   parameter int BITS  = 13,
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             xfer_start,
   input  logic [DIV_W-1:0] clk_div,
   output logic [5:0]       cfg_addr,
   input  logic [BITS-1:0]  cfg_data_1,
   input  logic [BITS-1:0]  cfg_data_2,
   output logic             busy,
   output logic             done,
   output logic             mprj_io_loader_resetn,
   output logic             mprj_io_loader_clock,
   output logic             mprj_io_loader_data_1,
   output logic             mprj_io_loader_data_2,
   output logic             mprj_io_loader_strobe,
   output logic [2:0]       dbg_state
);

   localparam int BCW = (BITS > 1) ? $clog2(BITS) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_SHIFT  = 3'd2,
      S_STROBE = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             phase_q, phase_d;
   logic [BCW-1:0]   bit_q, bit_d;
   logic [5:0]       addr_q, addr_d;
   logic [BITS-1:0]  sh1_q, sh1_d;
   logic [BITS-1:0]  sh2_q, sh2_d;
   logic             d1_q, d1_d;
   logic             d2_q, d2_d;
   logic             resetn_q;
   logic             last_div;

   // One phase (low or high half of a loader clock period) lasts div_q cycles.
   assign last_div = (div_cnt_q == (div_q - 1'b1));

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      div_cnt_d = div_cnt_q;
      phase_d   = phase_q;
      bit_d     = bit_q;
      addr_d    = addr_q;
      sh1_d     = sh1_q;
      sh2_d     = sh2_q;
      d1_d      = d1_q;
      d2_d      = d2_q;

      case (state_q)
         S_IDLE: begin
            if (xfer_start) begin
               state_d = S_FETCH;
               div_d   = (clk_div == '0) ? DIV_W'(1) : clk_div;
               addr_d  = 6'(PADS - 1);
            end
         end

         S_FETCH: begin
            sh1_d     = cfg_data_1;
            sh2_d     = cfg_data_2;
            bit_d     = BCW'(BITS - 1);
            div_cnt_d = '0;
            phase_d   = 1'b0;
            d1_d      = cfg_data_1[BITS-1];
            d2_d      = cfg_data_2[BITS-1];
            state_d   = S_SHIFT;
         end

         S_SHIFT: begin
            if (!last_div) begin
               div_cnt_d = div_cnt_q + 1'b1;
            end else begin
               div_cnt_d = '0;
               if (!phase_q) begin
                  phase_d = 1'b1;
               end else begin
                  // End of high phase: advance to the next bit or word.
                  phase_d = 1'b0;
                  sh1_d   = sh1_q << 1;
                  sh2_d   = sh2_q << 1;
                  if (bit_q == '0) begin
                     if (addr_q == '0) begin
                        state_d = S_STROBE;
                     end else begin
                        addr_d  = addr_q - 1'b1;
                        state_d = S_FETCH;
                     end
                  end else begin
                     bit_d = bit_q - 1'b1;
                     d1_d  = sh1_q[BITS-2];
                     d2_d  = sh2_q[BITS-2];
                  end
               end
            end
         end

         S_STROBE: begin
            // Two back-to-back phases of div_q cycles give a 2*D strobe.
            if (!last_div) begin
               div_cnt_d = div_cnt_q + 1'b1;
            end else begin
               div_cnt_d = '0;
               if (!phase_q) begin
                  phase_d = 1'b1;
               end else begin
                  phase_d = 1'b0;
                  state_d = S_DONE;
                  addr_d  = 6'(PADS - 1);
                  d1_d    = 1'b0;
                  d2_d    = 1'b0;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         div_q     <= DIV_W'(1);
         div_cnt_q <= '0;
         phase_q   <= 1'b0;
         bit_q     <= '0;
         addr_q    <= 6'(PADS - 1);
         sh1_q     <= '0;
         sh2_q     <= '0;
         d1_q      <= 1'b0;
         d2_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         div_cnt_q <= div_cnt_d;
         phase_q   <= phase_d;
         bit_q     <= bit_d;
         addr_q    <= addr_d;
         sh1_q     <= sh1_d;
         sh2_q     <= sh2_d;
         d1_q      <= d1_d;
         d2_q      <= d2_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resetn_q <= 1'b0;
      end else begin
         resetn_q <= 1'b1;
      end
   end

   assign busy                  = (state_q == S_FETCH) || (state_q == S_SHIFT) ||
                                  (state_q == S_STROBE);
   assign done                  = (state_q == S_DONE);
   assign cfg_addr              = addr_q;
   assign mprj_io_loader_resetn = resetn_q;
   assign mprj_io_loader_clock  = (state_q == S_SHIFT) && phase_q;
   assign mprj_io_loader_data_1 = d1_q;
   assign mprj_io_loader_data_2 = d2_q;
   assign mprj_io_loader_strobe = (state_q == S_STROBE);
   assign dbg_state             = state_q;

endmodule

// File: tb/tb_gpio_cfg_serializer.sv
// Randomized bench for gpio_cfg_serializer: models the two loader chains as plain
// shift registers on loader clock rises and compares slots against the register file.
module tb_gpio_cfg_serializer;

   localparam int PADS = 19;
   localparam int BITS = 13;
   localparam int NB   = PADS * BITS;

   logic            clk = 1'b0;
   logic            reset;
   logic            xfer_start;
   logic [7:0]      clk_div;
   logic [5:0]      cfg_addr;
   logic [BITS-1:0] cfg_data_1, cfg_data_2;
   logic            busy, done;
   logic            mprj_io_loader_resetn, mprj_io_loader_clock;
   logic            mprj_io_loader_data_1, mprj_io_loader_data_2;
   logic            mprj_io_loader_strobe;
   logic [2:0]      dbg_state;

   logic [BITS-1:0] reg1 [PADS];
   logic [BITS-1:0] reg2 [PADS];

   int n_checks = 0;
   int n_errors = 0;

   // monitor state
   int            rises, strobe_cyc, strobe_pulses, viol;
   int            hi_run, lo_run, stable_cnt, exp_d;
   bit            prev_clk, prev_strobe, had_fall;
   logic          pd1, pd2;
   logic [NB-1:0] ch1, ch2;

   gpio_cfg_serializer dut (
      .clk                   (clk),
      .reset                 (reset),
      .xfer_start            (xfer_start),
      .clk_div               (clk_div),
      .cfg_addr              (cfg_addr),
      .cfg_data_1            (cfg_data_1),
      .cfg_data_2            (cfg_data_2),
      .busy                  (busy),
      .done                  (done),
      .mprj_io_loader_resetn (mprj_io_loader_resetn),
      .mprj_io_loader_clock  (mprj_io_loader_clock),
      .mprj_io_loader_data_1 (mprj_io_loader_data_1),
      .mprj_io_loader_data_2 (mprj_io_loader_data_2),
      .mprj_io_loader_strobe (mprj_io_loader_strobe),
      .dbg_state             (dbg_state)
   );

   // clock / reset-independent register file read
   always #5 clk = ~clk;

   assign cfg_data_1 = (cfg_addr < 6'(PADS)) ? reg1[cfg_addr[4:0]] : '0;
   assign cfg_data_2 = (cfg_addr < 6'(PADS)) ? reg2[cfg_addr[4:0]] : '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int exp_lat(input int d);
      return 1 + PADS * (1 + BITS * 2 * d) + 2 * d;
   endfunction

   // Chain model: every loader clock rise pushes one bit in; also tracks phase
   // lengths and data stability around each rise.
   always @(negedge clk) begin
      if (!reset) begin
         bit changed;
         changed = (mprj_io_loader_data_1 !== pd1) || (mprj_io_loader_data_2 !== pd2);
         if (mprj_io_loader_clock && !prev_clk) begin
            rises++;
            ch1 = {ch1[NB-2:0], mprj_io_loader_data_1};
            ch2 = {ch2[NB-2:0], mprj_io_loader_data_2};
            if (changed || stable_cnt < exp_d) viol++;
            if (had_fall && lo_run != exp_d && lo_run != exp_d + 1) viol++;
            hi_run = 1;
         end else if (mprj_io_loader_clock) begin
            hi_run++;
            if (changed) viol++;
         end else if (prev_clk) begin
            if (hi_run != exp_d) viol++;
            had_fall = 1'b1;
            lo_run   = 1;
         end else begin
            lo_run++;
         end
         stable_cnt = changed ? 1 : stable_cnt + 1;
         if (mprj_io_loader_strobe) strobe_cyc++;
         if (mprj_io_loader_strobe && !prev_strobe) strobe_pulses++;
         if (mprj_io_loader_strobe && mprj_io_loader_clock) viol++;
         prev_clk    = mprj_io_loader_clock;
         prev_strobe = mprj_io_loader_strobe;
         pd1         = mprj_io_loader_data_1;
         pd2         = mprj_io_loader_data_2;
      end
   end

   task automatic clear_mon();
      rises = 0; strobe_cyc = 0; strobe_pulses = 0; viol = 0;
      hi_run = 0; lo_run = 0; stable_cnt = 0;
      prev_clk = 1'b0; prev_strobe = 1'b0; had_fall = 1'b0;
      pd1 = mprj_io_loader_data_1; pd2 = mprj_io_loader_data_2;
      ch1 = '0; ch2 = '0;
   endtask

   task automatic load_regs(input bit pattern);
      logic [BITS-1:0] base;
      base = 13'h1000;
      for (int k = 0; k < PADS; k++) begin
         if (pattern) begin
            reg1[k] = base >> k;
            reg2[k] = ~(base >> k);
         end else begin
            reg1[k] = BITS'($urandom);
            reg2[k] = BITS'($urandom);
         end
      end
   endtask

   // Starts a transfer in the current cycle and returns #1 after the edge that
   // enters the done cycle (or after the cycle budget expires).
   task automatic run_xfer(input string tag, input logic [7:0] div, input int p1, input int p2,
                           input int chg_at, input logic [7:0] chg_div, output int lat);
      int k;
      @(posedge clk); #1;
      check({tag, " idle busy"}, 32'(busy), 32'd0);
      clear_mon();
      exp_d      = (div == 8'd0) ? 1 : int'(div);
      clk_div    = div;
      xfer_start = 1'b1;
      k   = 0;
      lat = -1;
      while (k < 5000 && lat < 0) begin
         @(posedge clk); #1;
         k++;
         xfer_start = (k == p1) || (k == p2);
         if (k == chg_at) clk_div = chg_div;
         if (k == 1) check({tag, " busy"}, 32'(busy), 32'd1);
         if (done) lat = k;
      end
      xfer_start = 1'b0;
      check({tag, " latency"}, 32'(lat), 32'(exp_lat(exp_d)));
      check({tag, " done busy"}, 32'(busy), 32'd0);
      check({tag, " done addr"}, 32'(cfg_addr), 32'(PADS - 1));
      check({tag, " rises"}, 32'(rises), 32'(NB));
      check({tag, " strobe cyc"}, 32'(strobe_cyc), 32'(2 * exp_d));
      check({tag, " strobe pulses"}, 32'(strobe_pulses), 32'd1);
      check({tag, " timing viol"}, 32'(viol), 32'd0);
      check({tag, " data zero"}, 32'({mprj_io_loader_data_1, mprj_io_loader_data_2}), 32'd0);
      for (int s = 0; s < PADS; s++) begin
         check($sformatf("%s c1 slot%0d", tag, s), 32'(ch1[s*BITS +: BITS]), 32'(reg1[s]));
         check($sformatf("%s c2 slot%0d", tag, s), 32'(ch2[s*BITS +: BITS]), 32'(reg2[s]));
      end
   endtask

   task automatic settle_idle(input string tag);
      repeat (3) @(posedge clk);
      #1;
      check({tag, " idle after"}, 32'({busy, done, mprj_io_loader_strobe}), 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " busy"}, 32'(busy), 32'd0);
      check({tag, " done"}, 32'(done), 32'd0);
      check({tag, " addr"}, 32'(cfg_addr), 32'(PADS - 1));
      check({tag, " lclk"}, 32'(mprj_io_loader_clock), 32'd0);
      check({tag, " data"}, 32'({mprj_io_loader_data_1, mprj_io_loader_data_2}), 32'd0);
      check({tag, " strobe"}, 32'(mprj_io_loader_strobe), 32'd0);
      check({tag, " resetn"}, 32'(mprj_io_loader_resetn), 32'd0);
   endtask

   initial begin
      int lat;
      int k;
      logic [7:0] rd;
      reset      = 1'b1;
      xfer_start = 1'b0;
      clk_div    = 8'd1;
      load_regs(1'b0);
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("rst");
      reset = 1'b0;
      check("rst resetn hold", 32'(mprj_io_loader_resetn), 32'd0);
      @(posedge clk); #1;
      check("rst resetn up", 32'(mprj_io_loader_resetn), 32'd1);

      load_regs(1'b1);
      run_xfer("pattern", 8'd1, -1, -1, -1, 8'd0, lat);
      settle_idle("pattern");

      load_regs(1'b0);
      run_xfer("div3", 8'd3, -1, -1, -1, 8'd0, lat);
      settle_idle("div3");

      load_regs(1'b0);
      run_xfer("div0", 8'd0, -1, -1, -1, 8'd0, lat);
      settle_idle("div0");

      load_regs(1'b0);
      run_xfer("busy_start", 8'd1, 10, 300, -1, 8'd0, lat);
      settle_idle("busy_start");

      load_regs(1'b0);
      run_xfer("div_change", 8'd1, -1, -1, 50, 8'd5, lat);
      clk_div = 8'd1;
      settle_idle("div_change");

      for (int r = 0; r < 3; r++) begin
         load_regs(1'b0);
         rd = 8'($urandom_range(1, 4));
         run_xfer($sformatf("rand%0d", r), rd, -1, -1, -1, 8'd0, lat);
      end
      settle_idle("rand");

      // back-to-back: start held through the done cycle and the idle cycle after it
      load_regs(1'b0);
      run_xfer("b2b_a", 8'd1, -1, -1, -1, 8'd0, lat);
      xfer_start = 1'b1;
      run_xfer("b2b_b", 8'd1, -1, -1, -1, 8'd0, lat);
      settle_idle("b2b");

      // asynchronous reset mid-transfer
      load_regs(1'b0);
      @(posedge clk); #1;
      clear_mon();
      exp_d      = 1;
      clk_div    = 8'd1;
      xfer_start = 1'b1;
      k = 0;
      while (k < 200) begin
         @(posedge clk); #1;
         k++;
         xfer_start = 1'b0;
      end
      check("abort busy pre", 32'(busy), 32'd1);
      #2 reset = 1'b1;
      #1;
      check_reset_vals("abort");
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort strobe seen", 32'(strobe_pulses), 32'd0);
      check("abort done", 32'(done), 32'd0);
      @(posedge clk); #1;
      check("abort resetn up", 32'(mprj_io_loader_resetn), 32'd1);
      load_regs(1'b0);
      run_xfer("after_abort", 8'd2, -1, -1, -1, 8'd0, lat);
      settle_idle("after_abort");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
